// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage of nano_rv32i. Owns the PC and issues one word read
//   at a time to instruction memory. The fetched word goes to the decoder with
//   a valid/ready handshake. Branch/jump redirects from execute replace the PC,
//   and any response that is still in flight is discarded.
//
// Parameters
//   RESET_PC  PC loaded on reset (word aligned)
//   PC_INC    byte increment per sequential fetch
//
// Ports
//   clk_i          clock, all state on rising edge
//   rst_ni         synchronous active-low reset
//   pc_write_i     0 = stall: no new request is issued
//   redirect_i     taken branch/jump this cycle
//   redirect_pc_i  redirect target
//   imem_req_o     one-cycle read request strobe
//   imem_addr_o    word address of the request
//   imem_rvalid_i  read data valid
//   imem_rdata_i   read data
//   instr_valid_o  instr_o / pc_o valid for the decoder
//   instr_ready_i  decoder consumes instr_o this cycle
//   instr_o        fetched instruction (NOP after reset)
//   pc_o           address of instr_o
//   fetch_err_o    misaligned redirect seen (sticky until reset)
//
// Build option
//   FETCH_ALIGN_CHK_EN  when defined, a redirect with redirect_pc_i[1:0] != 0
//                       parks the unit in an error state (fetch_err_o = 1, no
//                       further requests). When undefined, the low target bits
//                       are cleared and fetch_err_o is tied to 0.
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_INC   = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        pc_write_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        fetch_err_o
);

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
`ifdef FETCH_ALIGN_CHK_EN
    localparam logic [1:0] S_ERR  = 2'd3;
`endif

    localparam logic [31:0] PC_STEP = 32'(PC_INC);
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        kill_q, kill_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        req_issue;
    logic [31:0] redirect_tgt;
    logic [1:0]  redirect_state;

    assign redirect_tgt = {redirect_pc_i[31:2], 2'b00};

`ifdef FETCH_ALIGN_CHK_EN
    // A misaligned target sends the unit to the sticky error state instead of REQ.
    assign redirect_state = (redirect_pc_i[1:0] != 2'b00) ? S_ERR : S_REQ;
    assign fetch_err_o    = (state_q == S_ERR);
`else
    logic unused_align_bits;
    assign unused_align_bits = ^redirect_pc_i[1:0];
    assign redirect_state    = S_REQ;
    assign fetch_err_o       = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        kill_d    = kill_q;
        instr_d   = instr_q;
        pc_out_d  = pc_out_q;
        req_issue = 1'b0;

        case (state_q)
            S_REQ: begin
                // A redirect suppresses the request; the target is fetched next cycle.
                if (redirect_i) begin
                    pc_d    = redirect_tgt;
                    state_d = redirect_state;
                end else if (pc_write_i) begin
                    req_issue = 1'b1;
                    state_d   = S_WAIT;
                end
            end

            S_WAIT: begin
                if (redirect_i) begin
                    pc_d = redirect_tgt;
                    if (redirect_state != S_REQ) begin
                        state_d = redirect_state;
                    end else if (imem_rvalid_i) begin
                        // Response arrives with the redirect: drop it and refetch.
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        // Response still in flight: mark it stale and keep waiting.
                        kill_d = 1'b1;
                    end
                end else if (imem_rvalid_i) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        instr_d  = imem_rdata_i;
                        pc_out_d = pc_q;
                        state_d  = S_HOLD;
                    end
                end
            end

            S_HOLD: begin
                // Redirect beats consumption: the held instruction is dropped.
                if (redirect_i) begin
                    pc_d    = redirect_tgt;
                    state_d = redirect_state;
                end else if (instr_ready_i) begin
                    pc_d    = pc_q + PC_STEP;
                    state_d = S_REQ;
                end
            end

`ifdef FETCH_ALIGN_CHK_EN
            S_ERR: begin
                // Sticky: only reset leaves this state; responses are ignored.
            end
`endif

            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= S_REQ;
            pc_q     <= RESET_PC;
            kill_q   <= 1'b0;
            instr_q  <= NOP;
            pc_out_q <= RESET_PC;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            kill_q   <= kill_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
        end
    end

    // The request strobe is combinational, so it is masked while reset is held.
    assign imem_req_o    = req_issue & rst_ni;
    assign imem_addr_o   = pc_q;
    assign instr_valid_o = (state_q == S_HOLD);
    assign instr_o       = instr_q;
    assign pc_o          = pc_out_q;

endmodule
